// File: rtl/rb_ctrl_if.sv
// rb_ctrl_if: pixel stream, row-buffer BRAM and steering signals of the row-buffer controller
interface rb_ctrl_if #(
  parameter int PIXEL_WIDTH = 8,
  parameter int RBs = 3,
  parameter int RB_ADDR = 2,
  parameter int BRAM_ADDR = 10
);
  logic                   s_valid;
  logic                   s_ready;
  logic [PIXEL_WIDTH-1:0] s_pixel;
  logic [RBs-1:0]         bram_we;
  logic [BRAM_ADDR-1:0]   bram_waddr;
  logic [PIXEL_WIDTH-1:0] bram_wdata;
  logic [BRAM_ADDR-1:0]   bram_raddr;
  logic                   steer_en;
  logic [RB_ADDR-1:0]     steer_sel;
  logic                   win_valid;
  modport master (
    input  s_valid, s_pixel,
    output s_ready, bram_we, bram_waddr, bram_wdata, bram_raddr, steer_en, steer_sel, win_valid
  );
  modport slave (
    output s_valid, s_pixel,
    input  s_ready, bram_we, bram_waddr, bram_wdata, bram_raddr, steer_en, steer_sel, win_valid
  );
endinterface

// File: rtl/rb_ctrl.sv
// rb_ctrl: row-buffer write/read sequencer and steering control for the window pipeline (RB_STALL_CNT_EN adds stall_cnt)
module rb_ctrl #(
  parameter int PIXEL_WIDTH = 8,
  parameter int RBs = 3,
  parameter int RB_ADDR = 2,
  parameter int BRAM_ADDR = 10,
  parameter int BRAM_R_DATA_WIDTH = 24,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  rb_ctrl_if.master bus,
  output logic      frame_done,
  output logic      busy
`ifdef RB_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);
  localparam int ROW_W = $clog2((IMG_H > RBs ? IMG_H : RBs) + 1);
  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;
  state_t state;
  logic [BRAM_ADDR-1:0] col;
  logic [ROW_W-1:0] row;
  logic [RB_ADDR-1:0] wr_rb;
  logic s_ready, beat;
  if (BRAM_R_DATA_WIDTH != RBs * PIXEL_WIDTH) begin : g_bad_width
    $error("BRAM_R_DATA_WIDTH must equal RBs*PIXEL_WIDTH");
  end
  assign s_ready = state == FILL || state == RUN;
  assign beat = s_ready && bus.s_valid;
  assign busy = state != IDLE;
  assign bus.s_ready = s_ready;
  assign bus.bram_we = beat ? RBs'(1) << wr_rb : '0;
  assign bus.bram_waddr = col;
  assign bus.bram_raddr = col;
  assign bus.bram_wdata = bus.s_pixel;
  // frame sequencing: counters, state and the steering controls delayed to match BRAM read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      col <= '0;
      row <= '0;
      wr_rb <= '0;
      bus.steer_en <= 1'b0;
      bus.steer_sel <= '0;
      bus.win_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      bus.steer_en <= beat;
      bus.win_valid <= beat && state == RUN;
      frame_done <= 1'b0;
      if (beat) bus.steer_sel <= wr_rb;
      case (state)
        IDLE: if (start) begin
          state <= FILL;
          col <= '0;
          row <= '0;
          wr_rb <= '0;
        end
        FILL, RUN: if (beat) begin
          if (col == BRAM_ADDR'(IMG_W - 1)) begin
            col <= '0;
            row <= row + 1'b1;
            wr_rb <= wr_rb == RB_ADDR'(RBs - 1) ? '0 : wr_rb + 1'b1;
            if (row == ROW_W'(IMG_H - 1)) begin
              state <= DONE;
              frame_done <= 1'b1;
            end else if (row == ROW_W'(RBs - 1)) state <= RUN;
          end else col <= col + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef RB_STALL_CNT_EN
  // input-starvation cycles while accepting pixels, saturating, restarted with each frame
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) stall_cnt <= '0;
    else if (s_ready && !bus.s_valid && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_rb_ctrl.sv
// tb_rb_ctrl: table vectors plus randomized frames checked against a beat-count reference model
module tb_rb_ctrl;
  localparam int PW = 8, RBS = 3, RA = 2, BA = 10, IW = 8, IH = 6;
  typedef struct {
    logic st;
    logic v;
    logic rdy;
    logic [RBS-1:0] we;
    logic [BA-1:0] addr;
    logic busy;
  } vec_t;
  logic clk = 0, rst = 1, start = 0, frame_done, busy;
  int total = 0, bad = 0;
  int m_st = 0, m_n = 0, wv_cnt = 0, fd_cnt = 0;
  logic [RA-1:0] m_sel = '0;
  logic [15:0] m_stall = '0;
  logic [PW-1:0] mem [RBS][IW];
  logic [PW-1:0] pix [IH][IW];
  logic [PW-1:0] rd [RBS];
  logic rdy_s;
  logic [RBS-1:0] we_s;
  logic [BA-1:0] addr_s;
  vec_t tbl [6];
  always #5 clk = ~clk;
  rb_ctrl_if #(.PIXEL_WIDTH(PW), .RBs(RBS), .RB_ADDR(RA), .BRAM_ADDR(BA)) bus ();
`ifdef RB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  rb_ctrl #(
    .PIXEL_WIDTH(PW), .RBs(RBS), .RB_ADDR(RA), .BRAM_ADDR(BA),
    .BRAM_R_DATA_WIDTH(RBS * PW), .IMG_W(IW), .IMG_H(IH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .bus(bus.master),
    .frame_done(frame_done),
    .busy(busy)
`ifdef RB_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, a, e, $time);
    end
  endtask
  task automatic cycle(input logic st, input logic v, input logic [PW-1:0] px, input logic r);
    bit beat, last;
    int row, col;
    @(negedge clk);
    rst = r;
    start = st;
    bus.s_valid = v;
    bus.s_pixel = px;
    #1;
    row = m_n / IW;
    col = m_n % IW;
    beat = !r && v && m_st == 1;
    last = beat && m_n == IW * IH - 1;
    rdy_s = bus.s_ready;
    we_s = bus.bram_we;
    addr_s = bus.bram_waddr;
    chk("wdata", bus.bram_wdata, px);
    if (!r) begin
      chk("s_ready", bus.s_ready, m_st == 1);
      chk("bram_we", bus.bram_we, beat ? (1 << (row % RBS)) : 0);
      if (m_st == 1) begin
        chk("waddr", bus.bram_waddr, col);
        chk("raddr", bus.bram_raddr, col);
      end
    end
    if (beat) begin
      for (int k = 0; k < RBS; k++) rd[k] = mem[k][col];
      mem[row % RBS][col] = px;
      pix[row][col] = px;
    end
    @(posedge clk);
    #1;
    if (r || (m_st == 0 && st)) m_stall = '0;
    else if (m_st == 1 && !v && m_stall != 16'hFFFF) m_stall++;
    if (r) begin
      m_st = 0;
      m_n = 0;
      m_sel = '0;
    end else if (m_st == 2) m_st = 0;
    else if (m_st == 0 && st) begin
      m_st = 1;
      m_n = 0;
    end else if (beat) begin
      m_sel = RA'(row % RBS);
      m_n++;
      if (last) m_st = 2;
    end
    if (r) begin
      chk("rst_we", bus.bram_we, 0);
      chk("rst_ready", bus.s_ready, 0);
      chk("rst_addr", bus.bram_waddr, 0);
    end
    chk("busy", busy, m_st != 0);
    chk("steer_en", bus.steer_en, beat);
    chk("steer_sel", bus.steer_sel, m_sel);
    chk("win_valid", bus.win_valid, beat && row >= RBS);
    chk("frame_done", frame_done, last);
    if (beat && row >= RBS)
      for (int j = 0; j < RBS; j++)
        chk("lane", rd[(int'(bus.steer_sel) + j) % RBS], pix[row - RBS + j][col]);
`ifdef RB_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
`endif
    wv_cnt += int'(bus.win_valid);
    fd_cnt += int'(frame_done);
  endtask
  task automatic run_frame(input bit rnd);
    int g = 0;
    while (m_st != 0 && g < 2000) begin
      cycle(rnd ? ($urandom % 8 == 0) : 1'b0, rnd ? 1'($urandom % 2) : 1'b1,
            rnd ? PW'($urandom) : PW'(m_n / IW), 1'b0);
      g++;
    end
    if (g == 2000) begin
      total++;
      bad++;
      $display("FAIL frame_timeout got=%0d want=idle", m_st);
    end
  endtask
  initial begin
    bus.s_valid = 0;
    bus.s_pixel = 0;
    tbl[0] = '{1'b0, 1'b1, 1'b0, 3'b000, 10'd0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 3'b000, 10'd0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 3'b001, 10'd0, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 3'b000, 10'd1, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 3'b001, 10'd1, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 3'b001, 10'd2, 1'b1};
    cycle(0, 1, 8'h5a, 1);
    cycle(0, 0, 8'h00, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sel", bus.steer_sel, 0);
    wv_cnt = 0;
    fd_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].st, tbl[i].v, PW'(m_n / IW), 1'b0);
      chk($sformatf("tbl%0d_ready", i), rdy_s, tbl[i].rdy);
      chk($sformatf("tbl%0d_we", i), we_s, tbl[i].we);
      chk($sformatf("tbl%0d_addr", i), addr_s, tbl[i].addr);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
    end
    run_frame(0);
    chk("a_win_cnt", wv_cnt, IW * (IH - RBS));
    chk("a_done_cnt", fd_cnt, 1);
    repeat (4) cycle(0, 1'($urandom % 2), PW'($urandom), 0);
    wv_cnt = 0;
    fd_cnt = 0;
    cycle(1, 1, 8'h11, 0);
    run_frame(1);
    chk("b_win_cnt", wv_cnt, IW * (IH - RBS));
    chk("b_done_cnt", fd_cnt, 1);
    cycle(1, 0, 8'h00, 0);
    while (m_n < 4 * IW + 3) cycle(0, 1, PW'(m_n / IW), 0);
    cycle(0, 1, 8'h04, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_win", bus.win_valid, 0);
    chk("mid_rst_sel", bus.steer_sel, 0);
    wv_cnt = 0;
    fd_cnt = 0;
    cycle(1, 0, 8'h00, 0);
    run_frame(0);
    chk("c_win_cnt", wv_cnt, IW * (IH - RBS));
    chk("c_done_cnt", fd_cnt, 1);
`ifdef RB_STALL_CNT_EN
    cycle(1, 0, 8'h00, 0);
    repeat (5) cycle(0, 0, 8'h00, 0);
    chk("stall_5", stall_cnt, 16'd5);
    repeat (70000) cycle(0, 0, 8'h00, 0);
    chk("stall_sat", stall_cnt, 16'hFFFF);
    run_frame(0);
    cycle(1, 0, 8'h00, 0);
    chk("stall_clr", stall_cnt, 16'd0);
    run_frame(0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rb_ctrl.md
# rb_ctrl

Sequencing controller for the BRAM row-buffer (RB) bank feeding the steering network of the neighbourhood-image-processing pipeline. It accepts a raster pixel stream over a valid/ready handshake, writes each row into the RBs circularly, issues the matching column read across all RBs, and drives the steering enable and select. The steering network then presents the RB lanes oldest-row-first. It also flags when a full vertical window column is valid and signals end of frame.

## Interface
Parameters:
- PIXEL_WIDTH, 8, bits per pixel
- RBs, 3, number of row buffers (window height), ≥2
- RB_ADDR, 2, width of steer select, clog2(RBs)
- BRAM_ADDR, 10, BRAM column address width; IMG_W ≤ 2**BRAM_ADDR
- BRAM_R_DATA_WIDTH, 24, RBs*PIXEL_WIDTH
- IMG_W, 640, pixels per row
- IMG_H, 480, rows per frame, ≥1

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  begin a frame; honoured only in IDLE
- s_valid  in  1  pixel valid
- s_ready  out  1  controller accepts pixel
- s_pixel  in  PIXEL_WIDTH  pixel data
- bram_we  out  RBs  one-hot write enable, bit k = RB k
- bram_waddr  out  BRAM_ADDR  write column
- bram_wdata  out  PIXEL_WIDTH  write data (= s_pixel)
- bram_raddr  out  BRAM_ADDR  read column, all RBs in parallel
- steer_en  out  1  steering enable
- steer_sel  out  RB_ADDR  steering rotation
- win_valid  out  1  steered BRAM word is a valid window column
- frame_done  out  1  one-cycle end-of-frame pulse
- busy  out  1  high outside IDLE

## Operation
- States: IDLE, FILL, RUN, DONE. Counters: col (0..IMG_W-1), row (0..IMG_H-1), wr_rb (0..RBs-1).
- IDLE: s_ready=0. start=1 → FILL, with col, row and wr_rb cleared.
- FILL: rows 0..RBs-1. RUN: rows ≥RBs. DONE: lasts one cycle, frame_done=1, then IDLE.
- s_ready=1 in FILL and RUN only. An accepted pixel is a cycle with s_valid&s_ready (a "beat").
- On a beat:
  - bram_we = 1<<wr_rb; bram_waddr = bram_raddr = col; bram_wdata = s_pixel. These are combinational from the registered counters and the handshake.
  - bram_we=0 on non-beat cycles; addresses hold col.
- BRAM is read-first: at a beat, lane wr_rb returns row−RBs (oldest) and lane (wr_rb+k)%RBs returns row−RBs+k.
- End of row (col=IMG_W-1 on a beat):
  - col→0, row+1.
  - wr_rb increments, wrapping RBs-1→0.
  - At row RBs-1 end: FILL→RUN.
- Last beat (row=IMG_H-1, col=IMG_W-1) → DONE, regardless of FILL or RUN.
- IMG_H≤RBs: RUN is never entered and win_valid never asserts.
- steer_sel = registered wr_rb of the beat, so steering output lane 0 = oldest row and lane RBs-1 = newest stored row.
- steer_en = registered beat flag. win_valid = registered (beat & state==RUN).
- start outside IDLE is ignored. s_valid in IDLE/DONE is ignored (no beat).
- Reset at any time → IDLE, counters 0, pending registered outputs cleared.

## Timing
- Reset values: s_ready=0, bram_we=0, bram_waddr=0, bram_raddr=0, bram_wdata=s_pixel passthrough, steer_en=0, steer_sel=0, win_valid=0, frame_done=0, busy=0.
- Write/read issue: same cycle as the beat (0 latency).
- steer_en, steer_sel, win_valid: 1 cycle after the beat, aligned with 1-cycle BRAM read data.
- The last beat's win_valid appears in the DONE cycle, coincident with frame_done.
- Throughput: 1 pixel/cycle. No output backpressure; the downstream consumer always accepts.
- start→first possible beat: 1 cycle (FILL entered at next edge).

## Configuration
- RB_STALL_CNT_EN defined: adds output stall_cnt [15:0].
  - Counts cycles in FILL/RUN with s_valid=0.
  - Saturates at 16'hFFFF; cleared on rst and on start accepted in IDLE.
- Not defined: no stall_cnt port, no counter logic; all other behaviour identical.

## Test plan
- Reset mid-RUN (RBs=3, IMG_W=8, IMG_H=6, rst during row 4) → next cycle busy=0, bram_we=0, win_valid=0, steer_sel=0; new start restarts at row 0, wr_rb=0.
- Continuous stream, RBs=3, IMG_W=8, IMG_H=6 → bram_we=001 for row 0, 010 for row 1, 100 for row 2, 001 for row 3. win_valid first high the cycle after row 3 col 0 with steer_sel=0. 24 win_valid cycles total. frame_done exactly once, the cycle after the 48th beat.
- Steering order: rows filled with pixel value = row index; during row 4 (wr_rb=1), steer_sel=1 and the steered lanes read 1,2,3 oldest-first.
- Bubbles: s_valid toggled 1/0 → bram_we only on valid cycles; col advances only on beats; steer_en/win_valid follow beats by exactly 1 cycle.
- Start while busy, and s_valid in IDLE → no state change, no writes, s_ready=0 in IDLE.
- RB_STALL_CNT_EN with 5 idle-input cycles in FILL → stall_cnt=5; forced 70000 idle cycles → stall_cnt=16'hFFFF; next start → 0.
